// File: rtl/cmem_arbiter.sv
// Arbitrates the cpu's instruction (a) and data (b) cmem ports onto one pmem port,
// keeping at most one downstream transaction in flight.
module cmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit PRIO_B = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                cmem_read_a,
  input  logic                cmem_write_a,
  input  logic [DATA_W/8-1:0] cmem_byte_enable_a,
  input  logic [ADDR_W-1:0]   cmem_address_a,
  input  logic [DATA_W-1:0]   cmem_wdata_a,
  output logic                cmem_resp_a,
  output logic [DATA_W-1:0]   cmem_rdata_a,

  input  logic                cmem_read_b,
  input  logic                cmem_write_b,
  input  logic [DATA_W/8-1:0] cmem_byte_enable_b,
  input  logic [ADDR_W-1:0]   cmem_address_b,
  input  logic [DATA_W-1:0]   cmem_wdata_b,
  output logic                cmem_resp_b,
  output logic [DATA_W-1:0]   cmem_rdata_b,

  output logic                pmem_read,
  output logic                pmem_write,
  output logic [DATA_W/8-1:0] pmem_byte_enable,
  output logic [ADDR_W-1:0]   pmem_address,
  output logic [DATA_W-1:0]   pmem_wdata,
  input  logic                pmem_resp,
  input  logic [DATA_W-1:0]   pmem_rdata
);

  typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic              req_a;
  logic              req_b;
  logic              grant_b;
  logic              served_b;
  logic              rr_b;
  logic [DATA_W-1:0] rdata_q;

  assign req_a = cmem_read_a | cmem_write_a;
  assign req_b = cmem_read_b | cmem_write_b;

  // rr_b means b is favoured on the next tie; it is cleared by reset so a wins first.
  assign grant_b = req_b & (~req_a | PRIO_B | rr_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_a | req_b) state_next = SERVE;
      SERVE:   if (pmem_resp) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmem_read        <= 1'b0;
      pmem_write       <= 1'b0;
      pmem_byte_enable <= '0;
      pmem_address     <= '0;
      pmem_wdata       <= '0;
      rdata_q          <= '0;
      served_b         <= 1'b0;
      rr_b             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_a | req_b) begin
            served_b <= grant_b;
            if (grant_b) begin
              pmem_write       <= cmem_write_b;
              pmem_read        <= cmem_read_b & ~cmem_write_b;
              pmem_byte_enable <= cmem_byte_enable_b;
              pmem_address     <= cmem_address_b;
              pmem_wdata       <= cmem_wdata_b;
            end else begin
              pmem_write       <= cmem_write_a;
              pmem_read        <= cmem_read_a & ~cmem_write_a;
              pmem_byte_enable <= cmem_byte_enable_a;
              pmem_address     <= cmem_address_a;
              pmem_wdata       <= cmem_wdata_a;
            end
          end
        end
        SERVE: begin
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            rdata_q    <= pmem_rdata;
          end
        end
        DONE: begin
          rr_b <= ~served_b;
        end
        default: begin
        end
      endcase
    end
  end

  assign cmem_resp_a  = (state == DONE) & ~served_b;
  assign cmem_resp_b  = (state == DONE) &  served_b;
  assign cmem_rdata_a = cmem_resp_a ? rdata_q : '0;
  assign cmem_rdata_b = cmem_resp_b ? rdata_q : '0;

endmodule

// File: tb/tb_cmem_arbiter.sv
// Directed bench: one instance with fixed b priority, one round-robin, sharing all inputs.
module tb_cmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmem_read_a, cmem_write_a, cmem_read_b, cmem_write_b;
  logic [BW-1:0] cmem_byte_enable_a, cmem_byte_enable_b;
  logic [AW-1:0] cmem_address_a, cmem_address_b;
  logic [DW-1:0] cmem_wdata_a, cmem_wdata_b;
  logic          pmem_resp;
  logic [DW-1:0] pmem_rdata;

  logic          cmem_resp_a_p, cmem_resp_b_p, pmem_read_p, pmem_write_p;
  logic [DW-1:0] cmem_rdata_a_p, cmem_rdata_b_p, pmem_wdata_p;
  logic [BW-1:0] pmem_byte_enable_p;
  logic [AW-1:0] pmem_address_p;

  logic          cmem_resp_a_r, cmem_resp_b_r, pmem_read_r, pmem_write_r;
  logic [DW-1:0] cmem_rdata_a_r, cmem_rdata_b_r, pmem_wdata_r;
  logic [BW-1:0] pmem_byte_enable_r;
  logic [AW-1:0] pmem_address_r;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  cmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_B(1'b1)) u_prio (
    .clk(clk), .rst_n(rst_n),
    .cmem_read_a(cmem_read_a), .cmem_write_a(cmem_write_a),
    .cmem_byte_enable_a(cmem_byte_enable_a), .cmem_address_a(cmem_address_a),
    .cmem_wdata_a(cmem_wdata_a), .cmem_resp_a(cmem_resp_a_p), .cmem_rdata_a(cmem_rdata_a_p),
    .cmem_read_b(cmem_read_b), .cmem_write_b(cmem_write_b),
    .cmem_byte_enable_b(cmem_byte_enable_b), .cmem_address_b(cmem_address_b),
    .cmem_wdata_b(cmem_wdata_b), .cmem_resp_b(cmem_resp_b_p), .cmem_rdata_b(cmem_rdata_b_p),
    .pmem_read(pmem_read_p), .pmem_write(pmem_write_p),
    .pmem_byte_enable(pmem_byte_enable_p), .pmem_address(pmem_address_p),
    .pmem_wdata(pmem_wdata_p), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  cmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_B(1'b0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .cmem_read_a(cmem_read_a), .cmem_write_a(cmem_write_a),
    .cmem_byte_enable_a(cmem_byte_enable_a), .cmem_address_a(cmem_address_a),
    .cmem_wdata_a(cmem_wdata_a), .cmem_resp_a(cmem_resp_a_r), .cmem_rdata_a(cmem_rdata_a_r),
    .cmem_read_b(cmem_read_b), .cmem_write_b(cmem_write_b),
    .cmem_byte_enable_b(cmem_byte_enable_b), .cmem_address_b(cmem_address_b),
    .cmem_wdata_b(cmem_wdata_b), .cmem_resp_b(cmem_resp_b_r), .cmem_rdata_b(cmem_rdata_b_r),
    .pmem_read(pmem_read_r), .pmem_write(pmem_write_r),
    .pmem_byte_enable(pmem_byte_enable_r), .pmem_address(pmem_address_r),
    .pmem_wdata(pmem_wdata_r), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  task automatic clear_req();
    cmem_read_a = 1'b0; cmem_write_a = 1'b0; cmem_read_b = 1'b0; cmem_write_b = 1'b0;
    cmem_byte_enable_a = '0; cmem_byte_enable_b = '0;
    cmem_address_a = '0; cmem_address_b = '0; cmem_wdata_a = '0; cmem_wdata_b = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_req();
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    #12;
    compared++;
    if ({pmem_read_p, pmem_write_p, cmem_resp_a_p, cmem_resp_b_p} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_strobes_prio: got %b expected 0000",
               {pmem_read_p, pmem_write_p, cmem_resp_a_p, cmem_resp_b_p});
    end
    compared++;
    if ({pmem_read_r, pmem_write_r, cmem_resp_a_r, cmem_resp_b_r} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_strobes_rr: got %b expected 0000",
               {pmem_read_r, pmem_write_r, cmem_resp_a_r, cmem_resp_b_r});
    end
    compared++;
    if ({pmem_address_p, pmem_wdata_p, pmem_byte_enable_p, cmem_rdata_a_p, cmem_rdata_b_p} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_fields: addr %h wdata %h be %h rdata_a %h rdata_b %h expected all 0",
               pmem_address_p, pmem_wdata_p, pmem_byte_enable_p, cmem_rdata_a_p, cmem_rdata_b_p);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    cmem_read_a = 1'b1;
    cmem_address_a = 32'h0000_0040;
    @(negedge clk);
    compared++;
    if ({pmem_read_p, pmem_write_p} !== 2'b10 || pmem_address_p !== 32'h40) begin
      mismatched++;
      $display("[TB] FAIL read_issue: rd/wr %b addr %h expected 10 / 00000040",
               {pmem_read_p, pmem_write_p}, pmem_address_p);
    end
    compared++;
    if (cmem_resp_a_p !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL read_early_resp: got %b expected 0", cmem_resp_a_p);
    end
    pmem_resp = 1'b1;
    pmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    compared++;
    if (cmem_resp_a_p !== 1'b1 || cmem_rdata_a_p !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("[TB] FAIL read_resp_a: resp %b rdata %h expected 1 / deadbeef",
               cmem_resp_a_p, cmem_rdata_a_p);
    end
    compared++;
    if (cmem_resp_b_p !== 1'b0 || pmem_read_p !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL read_done_other: resp_b %b pmem_read %b expected 0 / 0",
               cmem_resp_b_p, pmem_read_p);
    end
    clear_req();
    @(negedge clk);
    compared++;
    if (cmem_resp_a_p !== 1'b0 || cmem_rdata_a_p !== '0) begin
      mismatched++;
      $display("[TB] FAIL read_resp_one_cycle: resp %b rdata %h expected 0 / 0",
               cmem_resp_a_p, cmem_rdata_a_p);
    end
  endtask

  task automatic test_delayed_write();
    @(negedge clk);
    cmem_write_b = 1'b1;
    cmem_address_b = 32'h0000_0100;
    cmem_wdata_b = 32'h1234_5678;
    cmem_byte_enable_b = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      compared++;
      if ({pmem_read_p, pmem_write_p} !== 2'b01 || pmem_address_p !== 32'h100 ||
          pmem_wdata_p !== 32'h1234_5678 || pmem_byte_enable_p !== 4'b0011 || cmem_resp_b_p !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL write_hold[%0d]: rd/wr %b addr %h wdata %h be %b resp_b %b expected 01/100/12345678/0011/0",
                 k, {pmem_read_p, pmem_write_p}, pmem_address_p, pmem_wdata_p, pmem_byte_enable_p, cmem_resp_b_p);
      end
      if (k == 4) pmem_resp = 1'b1;
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    compared++;
    if (cmem_resp_b_p !== 1'b1 || cmem_resp_a_p !== 1'b0 || pmem_write_p !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL write_resp: resp_b %b resp_a %b pmem_write %b expected 1/0/0",
               cmem_resp_b_p, cmem_resp_a_p, pmem_write_p);
    end
    clear_req();
    @(negedge clk);
    compared++;
    if (cmem_resp_b_p !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL write_resp_once: got %b expected 0", cmem_resp_b_p);
    end
  endtask

  task automatic test_prio_b();
    @(negedge clk);
    cmem_read_a = 1'b1; cmem_address_a = 32'hA0;
    cmem_read_b = 1'b1; cmem_address_b = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      compared++;
      if ({pmem_read_p, pmem_write_p} !== 2'b10 || pmem_address_p !== 32'hB0) begin
        mismatched++;
        $display("[TB] FAIL prio_grant[%0d]: rd/wr %b addr %h expected 10 / 000000b0",
                 i, {pmem_read_p, pmem_write_p}, pmem_address_p);
      end
      pmem_resp = 1'b1;
      pmem_rdata = 32'h2222_2222;
      @(negedge clk);
      pmem_resp = 1'b0;
      compared++;
      if ({cmem_resp_a_p, cmem_resp_b_p} !== 2'b01 || cmem_rdata_b_p !== 32'h2222_2222) begin
        mismatched++;
        $display("[TB] FAIL prio_resp[%0d]: resp a/b %b rdata_b %h expected 01 / 22222222",
                 i, {cmem_resp_a_p, cmem_resp_b_p}, cmem_rdata_b_p);
      end
      @(negedge clk);
      compared++;
      if ({pmem_read_p, pmem_write_p, cmem_resp_a_p, cmem_resp_b_p} !== 4'b0000) begin
        mismatched++;
        $display("[TB] FAIL prio_idle_gap[%0d]: got %b expected 0000",
                 i, {pmem_read_p, pmem_write_p, cmem_resp_a_p, cmem_resp_b_p});
      end
    end
    clear_req();
  endtask

  task automatic test_round_robin();
    logic          exp_b;
    logic [DW-1:0] exp_data;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cmem_read_a = 1'b1; cmem_address_a = 32'hA0;
    cmem_read_b = 1'b1; cmem_address_b = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      exp_b = (i % 2) == 1;
      exp_data = exp_b ? 32'h2222_2222 : 32'h1111_1111;
      @(negedge clk);
      compared++;
      if (pmem_read_r !== 1'b1 || pmem_address_r !== (exp_b ? 32'hB0 : 32'hA0)) begin
        mismatched++;
        $display("[TB] FAIL rr_grant[%0d]: pmem_read %b addr %h expected 1 / %h",
                 i, pmem_read_r, pmem_address_r, exp_b ? 32'hB0 : 32'hA0);
      end
      pmem_resp = 1'b1;
      pmem_rdata = exp_data;
      @(negedge clk);
      pmem_resp = 1'b0;
      compared++;
      if ({cmem_resp_a_r, cmem_resp_b_r} !== {~exp_b, exp_b} ||
          cmem_rdata_a_r !== (exp_b ? 32'h0 : exp_data) || cmem_rdata_b_r !== (exp_b ? exp_data : 32'h0)) begin
        mismatched++;
        $display("[TB] FAIL rr_resp[%0d]: resp a/b %b rdata a %h b %h expected %b / data %h on port %s",
                 i, {cmem_resp_a_r, cmem_resp_b_r}, cmem_rdata_a_r, cmem_rdata_b_r,
                 {~exp_b, exp_b}, exp_data, exp_b ? "b" : "a");
      end
      @(negedge clk);
    end
    clear_req();
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    cmem_read_a = 1'b1;
    cmem_address_a = 32'h300;
    @(negedge clk);
    compared++;
    if (pmem_read_p !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL abort_pre: pmem_read %b expected 1", pmem_read_p);
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({pmem_read_p, pmem_read_r} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL abort_async_drop: pmem_read p/r %b expected 00", {pmem_read_p, pmem_read_r});
    end
    clear_req();
    @(negedge clk);
    rst_n = 1'b1;
    pmem_resp = 1'b1;
    pmem_rdata = 32'h0000_0BAD;
    @(negedge clk);
    pmem_resp = 1'b0;
    compared++;
    if ({cmem_resp_a_p, cmem_resp_b_p, cmem_resp_a_r, cmem_resp_b_r, pmem_read_p, pmem_write_p} !== 6'b0) begin
      mismatched++;
      $display("[TB] FAIL abort_late_resp: resp/strobes %b expected 000000",
               {cmem_resp_a_p, cmem_resp_b_p, cmem_resp_a_r, cmem_resp_b_r, pmem_read_p, pmem_write_p});
    end
    cmem_read_b = 1'b1;
    cmem_address_b = 32'h200;
    @(negedge clk);
    compared++;
    if (pmem_read_p !== 1'b1 || pmem_address_p !== 32'h200) begin
      mismatched++;
      $display("[TB] FAIL abort_next_issue: pmem_read %b addr %h expected 1 / 00000200",
               pmem_read_p, pmem_address_p);
    end
    pmem_resp = 1'b1;
    pmem_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    pmem_resp = 1'b0;
    compared++;
    if (cmem_resp_b_p !== 1'b1 || cmem_rdata_b_p !== 32'h5A5A_5A5A) begin
      mismatched++;
      $display("[TB] FAIL abort_next_resp: resp_b %b rdata %h expected 1 / 5a5a5a5a",
               cmem_resp_b_p, cmem_rdata_b_p);
    end
    clear_req();
    @(negedge clk);
  endtask

  task automatic test_read_write_both();
    @(negedge clk);
    cmem_read_a = 1'b1;
    cmem_write_a = 1'b1;
    cmem_address_a = 32'h80;
    cmem_wdata_a = 32'hCAFE_F00D;
    cmem_byte_enable_a = 4'b1111;
    @(negedge clk);
    compared++;
    if ({pmem_read_p, pmem_write_p} !== 2'b01 || pmem_address_p !== 32'h80 || pmem_wdata_p !== 32'hCAFE_F00D) begin
      mismatched++;
      $display("[TB] FAIL rw_both_issue: rd/wr %b addr %h wdata %h expected 01 / 00000080 / cafef00d",
               {pmem_read_p, pmem_write_p}, pmem_address_p, pmem_wdata_p);
    end
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    compared++;
    if (cmem_resp_a_p !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rw_both_resp: resp_a %b expected 1", cmem_resp_a_p);
    end
    clear_req();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_delayed_write();
    test_prio_b();
    test_round_robin();
    test_reset_abort();
    test_read_write_both();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
